// File: rtl/multicycle_seq.sv
// Multi-cycle instruction sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// gates the PC/IR/regfile/dmem strobes, counts retirements and traps on bad opcodes or timeouts.
module multicycle_seq #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       op,
    input  logic             done,
    input  logic             imem_rdy,
    input  logic             dmem_rdy,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_we,
    output logic             pc_we,
    output logic [2:0]       state,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] instret
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    localparam logic [1:0] C_LOAD   = 2'd0;
    localparam logic [1:0] C_STORE  = 2'd1;
    localparam logic [1:0] C_BRANCH = 2'd2;
    localparam logic [1:0] C_REG    = 2'd3;

    // Counter only ever needs to hold TIMEOUT-1 before it trips.
    localparam int                WAIT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [2:0]        state_q, state_d;
    logic [1:0]        cls_q, cls_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  instret_q, instret_d;

    logic       dec_legal;
    logic [1:0] dec_cls;
    logic       commit;
    logic       rdy;
    logic       tmo;
    logic [2:0] boundary;

    always_comb begin
        dec_legal = 1'b1;
        dec_cls   = C_REG;
        case (op)
            5'b00000: dec_cls = C_LOAD;
            5'b01000: dec_cls = C_STORE;
            5'b11000: dec_cls = C_BRANCH;
            5'b01101, 5'b00101, 5'b00100,
            5'b01100, 5'b11011, 5'b11001: dec_cls = C_REG;
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        wait_d    = wait_q;
        instret_d = instret_q;
        commit    = 1'b0;
        rdy       = (state_q == S_FETCH) ? imem_rdy : dmem_rdy;
        tmo       = (TIMEOUT != 0) && (wait_q == WAIT_LAST) && !rdy;
        boundary  = done ? S_HALT : S_FETCH;

        case (state_q)
            S_IDLE:   state_d = boundary;
            S_FETCH: begin
                if (imem_rdy)  state_d = S_DECODE;
                else if (tmo)  state_d = S_ERR;
            end
            S_DECODE: begin
                if (dec_legal) begin
                    cls_d   = dec_cls;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_ERR;
                end
            end
            S_EXEC: begin
                case (cls_q)
                    C_BRANCH: begin
                        commit  = 1'b1;
                        state_d = boundary;
                    end
                    C_REG:   state_d = S_WB;
                    default: state_d = S_MEM;
                endcase
            end
            S_MEM: begin
                if (dmem_rdy) begin
                    if (cls_q == C_STORE) begin
                        commit  = 1'b1;
                        state_d = boundary;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (tmo) begin
                    state_d = S_ERR;
                end
            end
            S_WB: begin
                commit  = 1'b1;
                state_d = boundary;
            end
            default: ; // HALT and ERR hold until reset
        endcase

        if (commit) instret_d = instret_q + CNT_W'(1);

        // Any state change restarts the wait count, so entry to FETCH/MEM always sees zero.
        if (state_d != state_q)
            wait_d = '0;
        else if ((state_q == S_FETCH || state_q == S_MEM) && !rdy)
            wait_d = wait_q + WAIT_W'(1);
    end

    always_comb begin
        imem_req = (state_q == S_FETCH);
        ir_we    = imem_req && imem_rdy;
        dmem_req = (state_q == S_MEM);
        dmem_we  = dmem_req && (cls_q == C_STORE);
        reg_we   = (state_q == S_WB);
        pc_we    = commit;
        state    = state_q;
        halted   = (state_q == S_HALT);
        err      = (state_q == S_ERR);
        instret  = instret_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cls_q     <= C_LOAD;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
        end
    end

endmodule

// File: tb/tb_multicycle_seq.sv
// Bench for multicycle_seq: builds a per-cycle expected trace from instruction-level rules
// (phases, waits, commits, boundaries) and replays it against the DUT.
module tb_multicycle_seq;

    localparam int TMO = 4;

    localparam bit [2:0] S_IDLE   = 3'd0;
    localparam bit [2:0] S_FETCH  = 3'd1;
    localparam bit [2:0] S_DECODE = 3'd2;
    localparam bit [2:0] S_EXEC   = 3'd3;
    localparam bit [2:0] S_MEM    = 3'd4;
    localparam bit [2:0] S_WB     = 3'd5;
    localparam bit [2:0] S_HALT   = 3'd6;
    localparam bit [2:0] S_ERR    = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  op;
    logic        done;
    logic        imem_rdy;
    logic        dmem_rdy;
    logic        imem_req;
    logic        ir_we;
    logic        dmem_req;
    logic        dmem_we;
    logic        reg_we;
    logic        pc_we;
    logic [2:0]  state;
    logic        halted;
    logic        err;
    logic [31:0] instret;

    always #5 clk = ~clk;

    multicycle_seq #(.CNT_W(32), .TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .op       (op),
        .done     (done),
        .imem_rdy (imem_rdy),
        .dmem_rdy (dmem_rdy),
        .imem_req (imem_req),
        .ir_we    (ir_we),
        .dmem_req (dmem_req),
        .dmem_we  (dmem_we),
        .reg_we   (reg_we),
        .pc_we    (pc_we),
        .state    (state),
        .halted   (halted),
        .err      (err),
        .instret  (instret)
    );

    // One record per clock: inputs to apply and outputs required in that cycle.
    typedef struct {
        bit        rst;
        bit        ird;
        bit        drd;
        bit [4:0]  op;
        bit        dn;
        bit        chk;
        bit [10:0] want;
        bit [31:0] cnt;
    } cyc_t;

    cyc_t      q[$];
    bit [31:0] cnt;
    int        n_cmp;
    int        n_bad;
    bit [4:0]  legal_ops[9] = '{5'b00000, 5'b01000, 5'b11000, 5'b01101, 5'b00101,
                                5'b00100, 5'b01100, 5'b11011, 5'b11001};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic bit rb();
        return bit'($urandom_range(1));
    endfunction

    function automatic bit [4:0] ro();
        return 5'($urandom);
    endfunction

    // 0 load, 1 store, 2 branch, 3 reg-writing, 4 illegal
    function automatic int cls(input bit [4:0] o);
        case (o)
            5'b00000: return 0;
            5'b01000: return 1;
            5'b11000: return 2;
            5'b01101, 5'b00101, 5'b00100, 5'b01100, 5'b11011, 5'b11001: return 3;
            default:  return 4;
        endcase
    endfunction

    // stb = {imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we}
    function automatic void push(input bit r, input bit ird, input bit drd, input bit [4:0] o,
                                 input bit dn, input bit [2:0] st, input bit [5:0] stb);
        cyc_t c;
        c.rst  = r;
        c.ird  = ird;
        c.drd  = drd;
        c.op   = o;
        c.dn   = dn;
        c.chk  = !r;
        c.want = {st, stb, st == S_HALT, st == S_ERR};
        c.cnt  = cnt;
        q.push_back(c);
        if (r) cnt = 0;
        else if (stb[0]) cnt++;
    endfunction

    function automatic void start(input bit dn);
        push(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, S_IDLE, 6'b0);
        push(1'b0, rb(), rb(), ro(), dn, S_IDLE, 6'b0);
    endfunction

    function automatic void tail(input bit [2:0] st, input int n);
        for (int i = 0; i < n; i++) push(1'b0, rb(), rb(), ro(), rb(), st, 6'b0);
    endfunction

    // Returns 0: committed to FETCH, 1: committed to HALT, 2: trapped to ERR, 3: aborted by reset.
    function automatic int run_instr(input bit [4:0] opc, input int iw, input int dw,
                                     input bit dn_end, input int rst_mem);
        int c;
        c = cls(opc);
        for (int i = 0; i < iw; i++) begin
            push(1'b0, 1'b0, rb(), ro(), rb(), S_FETCH, 6'b100000);
            if (i == TMO - 1) return 2;
        end
        push(1'b0, 1'b1, rb(), ro(), rb(), S_FETCH, 6'b110000);
        push(1'b0, rb(), rb(), opc, rb(), S_DECODE, 6'b0);
        if (c == 4) return 2;
        if (c == 2) begin
            push(1'b0, rb(), rb(), ro(), dn_end, S_EXEC, 6'b000001);
            return dn_end ? 1 : 0;
        end
        push(1'b0, rb(), rb(), ro(), rb(), S_EXEC, 6'b0);
        if (c <= 1) begin
            for (int i = 0; i < dw; i++) begin
                if (i == rst_mem) begin
                    push(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, S_IDLE, 6'b0);
                    return 3;
                end
                push(1'b0, rb(), 1'b0, ro(), rb(), S_MEM, {3'b001, c == 1, 2'b00});
                if (i == TMO - 1) return 2;
            end
            if (c == 1) begin
                push(1'b0, rb(), 1'b1, ro(), dn_end, S_MEM, 6'b001101);
                return dn_end ? 1 : 0;
            end
            push(1'b0, rb(), 1'b1, ro(), rb(), S_MEM, 6'b001000);
        end
        push(1'b0, rb(), rb(), ro(), dn_end, S_WB, 6'b000011);
        return dn_end ? 1 : 0;
    endfunction

    function automatic bit [4:0] pick();
        if ($urandom_range(9) == 0) return ro();
        return legal_ops[$urandom_range(8)];
    endfunction

    function automatic int pick_wait();
        if ($urandom_range(9) == 0) return TMO;
        return int'($urandom_range(2));
    endfunction

    initial begin
        int r;
        int n;
        bit d0;
        n_cmp = 0;
        n_bad = 0;
        cnt   = 0;
        rst = 1'b1; op = '0; done = 1'b0; imem_rdy = 1'b0; dmem_rdy = 1'b0;

        // Zero-wait ALU stream of three instructions.
        start(1'b0);
        r = run_instr(5'b01100, 0, 0, 1'b0, -1);
        r = run_instr(5'b01100, 0, 0, 1'b0, -1);
        r = run_instr(5'b01100, 0, 0, 1'b1, -1);
        tail(S_HALT, 3);
        // Load with two dmem wait cycles.
        start(1'b0);
        r = run_instr(5'b00000, 0, 2, 1'b1, -1);
        tail(S_HALT, 2);
        // Store then branch.
        start(1'b0);
        r = run_instr(5'b01000, 0, 0, 1'b0, -1);
        r = run_instr(5'b11000, 0, 0, 1'b1, -1);
        tail(S_HALT, 2);
        // Load halting at its boundary; HALT must stick.
        start(1'b0);
        r = run_instr(5'b00000, 1, 1, 1'b1, -1);
        tail(S_HALT, 5);
        // imem stuck low until timeout.
        start(1'b0);
        r = run_instr(5'b00100, TMO + 1, 0, 1'b0, -1);
        tail(S_ERR, 3);
        // Illegal opcode.
        start(1'b0);
        r = run_instr(5'b11111, 0, 0, 1'b0, -1);
        tail(S_ERR, 3);
        // Reset in the middle of MEM, then resume.
        start(1'b0);
        r = run_instr(5'b00101, 0, 0, 1'b0, -1);
        r = run_instr(5'b00000, 0, 3, 1'b0, 1);
        push(1'b0, rb(), rb(), ro(), 1'b0, S_IDLE, 6'b0);
        r = run_instr(5'b11000, 2, 0, 1'b1, -1);
        tail(S_HALT, 2);
        // done straight out of IDLE.
        start(1'b1);
        tail(S_HALT, 3);

        for (int s = 0; s < 40; s++) begin
            d0 = ($urandom_range(9) == 0);
            start(d0);
            if (d0) begin
                tail(S_HALT, 2);
                continue;
            end
            n = int'($urandom_range(6, 1));
            for (int k = 0; k < n; k++) begin
                r = run_instr(pick(), pick_wait(), pick_wait(), k == n - 1,
                              ($urandom_range(14) == 0) ? 0 : -1);
                if (r == 1) begin tail(S_HALT, 2); break; end
                if (r == 2) begin tail(S_ERR, 2); break; end
                if (r == 3) break;
            end
        end

        foreach (q[k]) begin
            rst      = q[k].rst;
            imem_rdy = q[k].ird;
            dmem_rdy = q[k].drd;
            op       = q[k].op;
            done     = q[k].dn;
            @(negedge clk);
            if (q[k].chk) begin
                chk($sformatf("c%0d outs{st,ireq,irwe,dreq,dwe,rwe,pcwe,hlt,err}", k),
                    {state, imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, halted, err},
                    q[k].want);
                chk($sformatf("c%0d instret", k), instret, q[k].cnt);
            end
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
